// File: rtl/moa_pkg.sv
// Shared constants and types for the 6-way total splitter.
// Widths are derived so that SW = W + clog2(N_OPS) holds by construction.
package moa_pkg;

  localparam int unsigned N_OPS = 6;
  localparam int unsigned W     = 8;
  localparam int unsigned IDX_W = $clog2(N_OPS);
  localparam int unsigned SW    = W + IDX_W;

  // Largest total that still splits into operands of W bits each.
  localparam logic [SW-1:0] MAX_TOTAL = SW'(N_OPS * ((2 ** W) - 1));

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(N_OPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    EMIT
  } state_t;

endpackage

// File: rtl/seq_const_div.sv
// Sequential restoring divider by a constant N: one quotient bit per cycle, MSB first.
// Loads on start, pulses done after SW steps; q keeps only the low QW quotient bits.
module seq_const_div #(
  parameter int unsigned N  = 6,
  parameter int unsigned SW = 11,
  parameter int unsigned QW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SW-1:0]          dividend,
  output logic                   done,
  output logic [QW-1:0]          q,
  output logic [$clog2(N)-1:0]   r
);

  localparam int unsigned RW = $clog2(N);
  localparam int unsigned CW = $clog2(SW + 1);
  localparam logic [RW:0] DIVISOR = (RW + 1)'(N);

  logic [SW-1:0] dvd;
  logic [CW-1:0] cnt;
  logic          busy;
  logic [RW:0]   trial;
  logic          fits;

  // Partial remainder with the next dividend bit shifted in; always below 2*N.
  always_comb begin
    trial = {r, dvd[SW-1]};
    fits  = (trial >= DIVISOR);
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block updates from its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      q    <= '0;
      r    <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvd  <= dividend;
        cnt  <= CW'(SW);
        busy <= 1'b1;
        q    <= '0;
        r    <= '0;
      end else if (busy) begin
        dvd <= {dvd[SW-2:0], 1'b0};
        // Upper quotient bits fall off the top; callers guarantee they are zero.
        q   <= {q[QW-2:0], fits};
        r   <= fits ? RW'(trial - DIVISOR) : trial[RW-1:0];
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/moa_split_6x8.sv
// Splits an SW-bit total into N_OPS balanced W-bit operands, larger ones first,
// streamed out with a valid/ready handshake after a sequential divide by N_OPS.
module moa_split_6x8
  import moa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SW-1:0]    in_total,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             err
);

  state_t       state;
  state_t       state_nxt;
  idx_t         idx;
  logic [W-1:0] quo;
  idx_t         rem;
  logic         accept;
  logic         over_max;
  logic         div_start;
  logic         div_done;
  logic         handshake;

  assign accept    = in_valid && in_ready;
  assign over_max  = (in_total > MAX_TOTAL);
  assign div_start = accept && !over_max;
  assign handshake = out_valid && out_ready;

  // The divider's dividend register doubles as the input latch for the total.
  seq_const_div #(
    .N  (N_OPS),
    .SW (SW),
    .QW (W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (in_total),
    .done     (div_done),
    .q        (quo),
    .r        (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal written here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !over_max) begin
          state_nxt = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && (idx == LAST_IDX)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (state == DIV) begin
      idx <= '0;
    end else if (handshake) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + idx_t'(1);
    end
  end

  // Out-of-range totals are consumed but only reported, never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= accept && over_max;
    end
  end

  // The first rem operands carry the extra unit; with rem == 0 quo+1 is never picked.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = (idx < rem) ? quo + W'(1) : quo;
    end
  end

  assign out_idx  = idx;
  assign out_last = out_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_moa_split_6x8.sv
// Randomized self-checking bench for moa_split_6x8 against a divide/modulo model
// of the balanced split, covering latency, backpressure, range errors and reset abort.
module tb_moa_split_6x8;

  localparam int NOPS = 6;
  localparam int MAXT = 1530;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_total;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moa_split_6x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_total  (in_total),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: total = 6*q + r, the first r operands are q+1, the rest q.
  function automatic int ref_op(input int total, input int i);
    int q;
    int r;
    q = total / NOPS;
    r = total % NOPS;
    return (i < r) ? q + 1 : q;
  endfunction

  // Present a total, wait for it to be taken; returns just after the acceptance edge.
  task automatic accept(input int total, input bit hold_valid, input int next_total);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_total = 11'(total);
    @(posedge clk);
    #1;
    in_valid = hold_valid;
    in_total = 11'(next_total);
  endtask

  // Collect one stream; cycle c counts from the acceptance edge (c = 0 right after it).
  task automatic collect(input int total, input bit rand_ready);
    int  n;
    int  sum;
    int  lasts;
    int  first;
    int  last_c;
    bit  dropped;
    n = 0; sum = 0; lasts = 0; first = -1; last_c = -1; dropped = 1'b0;
    for (int c = 0; c < 300 && n < NOPS; c++) begin
      @(negedge clk);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (c == 0) begin
        check("busy_in_ready", in_ready, 0);
        check("busy_err", err, 0);
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        check($sformatf("idx_t%0d_n%0d", total, n), out_idx, n);
        check($sformatf("data_t%0d_n%0d", total, n), out_data, ref_op(total, n));
        check($sformatf("last_t%0d_n%0d", total, n), out_last, (n == NOPS - 1) ? 1 : 0);
        if (out_ready) begin
          sum += int'(out_data);
          if (out_last === 1'b1) lasts++;
          n++;
          last_c = c;
        end
      end else if (first >= 0) begin
        dropped = 1'b1;
      end
    end
    check($sformatf("ops_done_t%0d", total), n, NOPS);
    check($sformatf("sum_t%0d", total), sum, total);
    check($sformatf("last_once_t%0d", total), lasts, 1);
    check($sformatf("no_valid_drop_t%0d", total), dropped, 0);
    check($sformatf("first_valid_cycle_t%0d", total), first, 12);
    if (!rand_ready) check($sformatf("last_op_cycle_t%0d", total), last_c, 17);
    @(negedge clk);
    check($sformatf("valid_after_stream_t%0d", total), out_valid, 0);
    check($sformatf("in_ready_after_stream_t%0d", total), in_ready, 1);
  endtask

  task automatic run_err(input int total);
    bit bad_valid;
    bit ready_low;
    bad_valid = 1'b0;
    ready_low = 1'b0;
    accept(total, 1'b0, 0);
    @(negedge clk);
    check($sformatf("err_pulse_t%0d", total), err, 1);
    check($sformatf("err_in_ready_t%0d", total), in_ready, 1);
    check($sformatf("err_no_valid_t%0d", total), out_valid, 0);
    @(negedge clk);
    check($sformatf("err_clear_t%0d", total), err, 0);
    repeat (14) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad_valid = 1'b1;
      if (in_ready !== 1'b1) ready_low = 1'b1;
    end
    check($sformatf("err_never_emits_t%0d", total), bad_valid, 0);
    check($sformatf("err_ready_stays_t%0d", total), ready_low, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_idx"}, out_idx, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_total  = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Main case with full latency check, then both legal extremes.
    accept(1000, 1'b0, 0);
    collect(1000, 1'b0);
    accept(0, 1'b0, 0);
    collect(0, 1'b0);
    accept(MAXT, 1'b0, 0);
    collect(MAXT, 1'b0);

    // Out-of-range totals.
    run_err(MAXT + 1);
    run_err(2047);

    // Random backpressure on a small total.
    accept(7, 1'b0, 0);
    collect(7, 1'b1);

    // Reset in the middle of division aborts at once.
    accept(999, 1'b0, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_valid", out_valid, 0);
    accept(13, 1'b0, 0);
    collect(13, 1'b0);

    // Back-to-back: request held high, second total taken as soon as in_ready returns.
    accept(6, 1'b1, 11);
    collect(6, 1'b0);
    check("b2b_still_requesting", in_valid, 1);
    accept(11, 1'b0, 0);
    collect(11, 1'b0);

    // Randomized totals across the whole input range.
    repeat (25) begin
      t = int'($urandom_range(0, 2047));
      if (t > MAXT) begin
        run_err(t);
      end else begin
        accept(t, 1'b0, 0);
        collect(t, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
